// File: rtl/bcd_scan_display.sv
// ============================================================================
// Module   : bcd_scan_display
// Brief    : Time-multiplexed common-anode 7-segment driver for a BCD counter
//            chain, with a per-frame input snapshot. Optional leading-zero
//            blanking is enabled by defining BCD_SCAN_LZB_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_scan_display #(
    parameter int CLK_DIV  = 1000,
    parameter int N_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame
);

    localparam int PRE_W = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [PRE_W-1:0]    c_pre_max = PRE_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]    c_idx_max = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] c_an_one  = N_DIGITS'(1);
    localparam logic [6:0]          c_blank   = 7'h7F;

    logic [PRE_W-1:0]      r_pre;
    logic [IDX_W-1:0]      r_idx;
    logic [4*N_DIGITS-1:0] r_snap_bcd;
    logic [N_DIGITS-1:0]   r_snap_dp;

    logic                  w_run;
    logic                  w_tick;
    logic                  w_sof;
    logic [3:0]            w_nib;
    logic [6:0]            w_seg_dec;
    logic [6:0]            w_seg;
    logic [N_DIGITS-1:0]   w_an;

    // enable is active-low: high freezes the scan
    assign w_run  = ~enable;
    assign w_tick = (r_pre == c_pre_max);
    assign w_sof  = w_run && (r_pre == '0) && (r_idx == '0);
    assign w_nib  = r_snap_bcd[{r_idx, 2'b00} +: 4];
    assign w_an   = ~(c_an_one << r_idx);

    always_comb begin
        w_seg_dec = 7'b0111111;
        case (w_nib)
            4'd0:    w_seg_dec = 7'b1000000;
            4'd1:    w_seg_dec = 7'b1111001;
            4'd2:    w_seg_dec = 7'b0100100;
            4'd3:    w_seg_dec = 7'b0110000;
            4'd4:    w_seg_dec = 7'b0011001;
            4'd5:    w_seg_dec = 7'b0010010;
            4'd6:    w_seg_dec = 7'b0000010;
            4'd7:    w_seg_dec = 7'b1111000;
            4'd8:    w_seg_dec = 7'b0000000;
            4'd9:    w_seg_dec = 7'b0010000;
            default: w_seg_dec = 7'b0111111;
        endcase
    end

`ifdef BCD_SCAN_LZB_EN
    logic [N_DIGITS-1:0] w_lead;

    // A digit is a leading zero while it and everything above it is a
    // zero nibble with no decimal point requested.
    always_comb begin : p_lzb
        logic w_chain;
        w_chain = 1'b1;
        w_lead  = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            w_chain   = w_chain & (r_snap_bcd[4*i +: 4] == 4'd0) & ~r_snap_dp[i];
            w_lead[i] = w_chain;
        end
        w_lead[0] = 1'b0;
    end

    assign w_seg = w_lead[r_idx] ? c_blank : w_seg_dec;
`else
    assign w_seg = w_seg_dec;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre      <= '0;
            r_idx      <= '0;
            r_snap_bcd <= '0;
            r_snap_dp  <= '0;
            an         <= '1;
            seg        <= c_blank;
            dp         <= 1'b1;
            frame      <= 1'b0;
        end else if (w_run) begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == c_idx_max) ? '0 : r_idx + 1'b1;
            end
            if (w_sof) begin
                r_snap_bcd <= bcd_in;
                r_snap_dp  <= dp_in;
            end
            frame <= w_sof;
            an    <= w_an;
            seg   <= w_seg;
            dp    <= ~r_snap_dp[r_idx];
        end else begin
            an    <= '1;
            seg   <= c_blank;
            dp    <= 1'b1;
            frame <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bcd_scan_display.sv
// Directed self-checking bench for bcd_scan_display (CLK_DIV=4, N_DIGITS=4).
`default_nettype none

module tb_bcd_scan_display;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected segment patterns, {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SB = 7'h7F;

`ifdef BCD_SCAN_LZB_EN
    localparam logic [6:0] SLZ = SB;
`else
    localparam logic [6:0] SLZ = S0;
`endif

    bcd_scan_display #(
        .CLK_DIV  (4),
        .N_DIGITS (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .bcd_in (bcd_in),
        .dp_in  (dp_in),
        .seg    (seg),
        .dp     (dp),
        .an     (an),
        .frame  (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        bcd_in = 16'h1234;
        dp_in  = 4'b0100;

        // Reset
        step(3);
        check("rst_an",    16'(an),    16'hF);
        check("rst_seg",   16'(seg),   16'(SB));
        check("rst_dp",    16'(dp),    16'h1);
        check("rst_frame", 16'(frame), 16'h0);

        // First edge after deassertion is an SOF edge (E1)
        rst = 1'b0;
        step(1);
        check("sof1_frame", 16'(frame), 16'h1);
        check("sof1_an",    16'(an),    16'hE);
        step(1);                                   // E2
        check("d0_seg",   16'(seg),   16'(S4));
        check("d0_an",    16'(an),    16'hE);
        check("d0_dp",    16'(dp),    16'h1);
        check("d0_frame", 16'(frame), 16'h0);
        step(3);                                   // E5
        check("d1_an",  16'(an),  16'hD);
        check("d1_seg", 16'(seg), 16'(S3));
        step(4);                                   // E9
        check("d2_an",  16'(an),  16'hB);
        check("d2_seg", 16'(seg), 16'(S2));
        check("d2_dp",  16'(dp),  16'h0);
        step(3);                                   // E12
        check("d2_end_an", 16'(an), 16'hB);
        check("d2_end_dp", 16'(dp), 16'h0);
        step(1);                                   // E13
        check("d3_an",  16'(an),  16'h7);
        check("d3_seg", 16'(seg), 16'(S1));
        check("d3_dp",  16'(dp),  16'h1);
        step(4);                                   // E17
        check("sof2_frame", 16'(frame), 16'h1);
        check("sof2_an",    16'(an),    16'hE);
        step(1);                                   // E18
        check("sof2_clr", 16'(frame), 16'h0);

        // Tear-free snapshot: 0999 captured at E33, 1000 applied mid-frame
        bcd_in = 16'h0999;
        dp_in  = 4'b0000;
        step(15);                                  // E33
        check("sof3_frame", 16'(frame), 16'h1);
        step(5);                                   // E38
        check("tear_d1_an",  16'(an),  16'hD);
        check("tear_d1_seg", 16'(seg), 16'(S9));
        bcd_in = 16'h1000;
        step(8);                                   // E46
        check("tear_d3_an",  16'(an),  16'h7);
        check("tear_d3_seg", 16'(seg), 16'(SLZ));
        step(16);                                  // E62
        check("new_d3_an",  16'(an),  16'h7);
        check("new_d3_seg", 16'(seg), 16'(S1));

        // Invalid BCD code shows a dash
        bcd_in = 16'h00A0;
        step(8);                                   // E70
        check("inv_d1_an",  16'(an),  16'hD);
        check("inv_d1_seg", 16'(seg), 16'(SD));
        step(8);                                   // E78
        check("inv_d3_seg", 16'(seg), 16'(SLZ));

        // Enable freeze during digit 2
        bcd_in = 16'h1234;
        dp_in  = 4'b0100;
        step(12);                                  // E90
        check("frz_pre_an", 16'(an), 16'hB);
        enable = 1'b1;
        step(1);                                   // E91
        check("frz_an",    16'(an),    16'hF);
        check("frz_seg",   16'(seg),   16'(SB));
        check("frz_dp",    16'(dp),    16'h1);
        step(9);                                   // E100
        check("frz_hold_an",    16'(an),    16'hF);
        check("frz_hold_frame", 16'(frame), 16'h0);
        enable = 1'b0;
        step(1);                                   // E101
        check("res_d2a_an",  16'(an),  16'hB);
        check("res_d2a_seg", 16'(seg), 16'(S2));
        step(1);                                   // E102
        check("res_d2b_an", 16'(an), 16'hB);
        step(1);                                   // E103
        check("res_d3_an",  16'(an),  16'h7);
        check("res_d3_seg", 16'(seg), 16'(S1));
        step(4);                                   // E107
        check("res_sof_frame", 16'(frame), 16'h1);

        // Leading zeros, 0050
        bcd_in = 16'h0050;
        dp_in  = 4'b0000;
        step(22);                                  // E129
        check("lz_d1_an",  16'(an),  16'hD);
        check("lz_d1_seg", 16'(seg), 16'(S5));
        step(4);                                   // E133
        check("lz_d2_an",  16'(an),  16'hB);
        check("lz_d2_seg", 16'(seg), 16'(SLZ));
        step(4);                                   // E137
        check("lz_d3_an",  16'(an),  16'h7);
        check("lz_d3_seg", 16'(seg), 16'(SLZ));
        step(3);                                   // E140
        check("lz_d0_an",  16'(an),  16'hE);
        check("lz_d0_seg", 16'(seg), 16'(S0));

        // All zeros with a decimal point on digit 2
        bcd_in = 16'h0000;
        dp_in  = 4'b0100;
        step(21);                                  // E161
        check("z_d1_seg", 16'(seg), 16'(S0));
        step(4);                                   // E165
        check("z_d2_seg", 16'(seg), 16'(S0));
        check("z_d2_dp",  16'(dp),  16'h0);
        step(4);                                   // E169
        check("z_d3_an",  16'(an),  16'h7);
        check("z_d3_seg", 16'(seg), 16'(SLZ));

        // Mid-frame reset
        rst = 1'b1;
        step(1);
        check("mrst_an",    16'(an),    16'hF);
        check("mrst_seg",   16'(seg),   16'(SB));
        check("mrst_frame", 16'(frame), 16'h0);
        rst = 1'b0;
        step(1);
        check("mrst_sof_frame", 16'(frame), 16'h1);
        check("mrst_sof_an",    16'(an),    16'hE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
